// File: rtl/led_blink_scheduler.sv
// Round-robin owner of a single board LED: grants one requester at a time and
// plays its burst of ON/OFF phases on a prescaled tick, then pulses its ack.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | LED free; round-robin search of req starting at rr_ptr
//   S_ON   | LED driven high for half ticks of the granted burst
//   S_OFF  | LED driven low for half ticks; repeats ON or finishes
//   S_DONE | one-cycle ack to the owner; grant and busy already dropped
module led_blink_scheduler #(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 5000,
  parameter int DIV_W    = 26
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   blink_cnt,
  input  logic [8*N_REQ-1:0]   half_per,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 LED
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       phase_q, phase_d;
  logic [7:0]       half_q, half_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;

  logic             tick;
  logic             phase_end;
  logic             owner_req;
  logic             req_found;
  logic [IDX_W-1:0] win_idx;
  logic [3:0]       win_cnt;
  logic [7:0]       win_half;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  assign tick      = (presc_q == DIV_W'(TICK_DIV - 1));
  assign phase_end = tick && (phase_q == (half_q - 8'd1));
  assign owner_req = req[owner_q];

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    req_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = int'(rr_ptr_q) + j;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!req_found && req[cand_idx]) begin
        req_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_cnt  = blink_cnt[4*win_idx +: 4];
    win_half = half_per[8*win_idx +: 8];
    if (win_cnt == 4'd0)  win_cnt  = 4'd1;
    if (win_half == 8'd0) win_half = 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    phase_d     = phase_q;
    half_d      = half_q;
    remaining_d = remaining_q;
    grant_d     = grant_q;
    ack_d       = '0;
    busy_d      = busy_q;
    led_d       = led_q;

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          owner_d          = win_idx;
          remaining_d      = win_cnt;
          half_d           = win_half;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          led_d            = 1'b1;
          phase_d          = '0;
          presc_d          = '0;
          rr_ptr_d         = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d          = S_ON;
        end
      end

      S_ON, S_OFF: begin
        if (!owner_req) begin
          // Abandoned burst: release the LED without an ack.
          state_d = S_IDLE;
          led_d   = 1'b0;
          grant_d = '0;
          busy_d  = 1'b0;
          phase_d = '0;
        end else if (phase_end) begin
          phase_d = '0;
          if (state_q == S_ON) begin
            led_d   = 1'b0;
            state_d = S_OFF;
          end else if (remaining_q > 4'd1) begin
            remaining_d = remaining_q - 4'd1;
            led_d       = 1'b1;
            state_d     = S_ON;
          end else begin
            led_d          = 1'b0;
            grant_d        = '0;
            busy_d         = 1'b0;
            ack_d[owner_q] = 1'b1;
            state_d        = S_DONE;
          end
        end else if (tick) begin
          phase_d = phase_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      phase_q     <= '0;
      half_q      <= '0;
      remaining_q <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      remaining_q <= remaining_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign LED   = led_q;

endmodule
